// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box finder and outline drawer.
// rowBase is a constant-coefficient shift-add product, not a general multiplier.
package bbox_pkg;

    localparam int DEF_WIDTH  = 100;
    localparam int DEF_HEIGHT = 100;
    localparam int DEF_ADDR_W = 15;
    localparam int COORD_W    = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        TOP,
        BOTTOM,
        LEFT,
        RIGHT,
        REJECT
    } state_t;

    // w is a parameter at every call site, so this folds to an adder tree
    function automatic logic [31:0] rowBase(input coord_t y, input int w);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (w[i]) begin
                acc = acc + ({21'd0, y} << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bbox_draw_if.sv
// Draw request handshake and frame-buffer write port.
interface bbox_draw_if
    import bbox_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              en;
    logic              rdy;
    coord_t            xMin;
    coord_t            xMax;
    coord_t            yMin;
    coord_t            yMax;
    logic [7:0]        colour;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wrdata;
    logic              wren;
    logic              err;

    modport master (
        output en, xMin, xMax, yMin, yMax, colour,
        input  rdy, addr, wrdata, wren, err
    );

    modport slave (
        input  en, xMin, xMax, yMin, yMax, colour,
        output rdy, addr, wrdata, wren, err
    );

endinterface

// File: rtl/bbox_addr_gen.sv
// Frame-buffer address register: loads row base + x, then steps
// by one pixel along a row or by one row down a column.
module bbox_addr_gen
    import bbox_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              rowStep,
    input  logic [ADDR_W-1:0] base,
    input  coord_t            x,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= base + ADDR_W'(x);
        end else if (step) begin
            addr <= addr + (rowStep ? ADDR_W'(WIDTH) : ADDR_W'(1));
        end
    end

endmodule

// File: rtl/bbox_draw.sv
// Draws a one-pixel rectangle outline into a frame buffer:
// top row, bottom row, left column, right column, one pixel per cycle.
module bbox_draw
    import bbox_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic        clk,
    input logic        rst_n,
    bbox_draw_if.slave bus
);

    state_t            state;
    coord_t            xMinR, xMaxR, yMinR, yMaxR;
    coord_t            xCur, yCur;
    logic [ADDR_W-1:0] rowTopR, rowBotR, rowNext, rowIn, rowInBot;
    logic [ADDR_W-1:0] ldBase, addrW;
    coord_t            ldX;
    logic              rdyR, wrenR, errR;
    logic [7:0]        wrdataR;
    logic              ld, stp, rowStp;
    logic              accept, badBox, lastX, lastY, tall;

    assign accept   = bus.en && rdyR;
    assign rowIn    = ADDR_W'(rowBase(bus.yMin, WIDTH));
    assign rowInBot = ADDR_W'(rowBase(bus.yMax, WIDTH));
    assign rowNext  = rowTopR + ADDR_W'(WIDTH);
    assign lastX    = xCur == xMaxR;
    assign lastY    = yCur == yMaxR - COORD_W'(1);
    assign tall     = (yMaxR - yMinR) >= COORD_W'(2);

    // Also catches the finder's empty result (xMin=WIDTH-1, xMax=0)
    assign badBox = (bus.xMin > bus.xMax)
                 || (bus.yMin > bus.yMax)
                 || (bus.xMax >= COORD_W'(WIDTH))
                 || (bus.yMax >= COORD_W'(HEIGHT));

    always_comb begin
        ld     = 1'b0;
        stp    = 1'b0;
        rowStp = 1'b0;
        ldBase = '0;
        ldX    = '0;
        unique case (state)
            IDLE: begin
                if (accept && !badBox) begin
                    ld     = 1'b1;
                    ldBase = rowIn;
                    ldX    = bus.xMin;
                end
            end
            TOP: begin
                if (!lastX) begin
                    stp = 1'b1;
                end else if (yMinR != yMaxR) begin
                    ld     = 1'b1;
                    ldBase = rowBotR;
                    ldX    = xMinR;
                end
            end
            BOTTOM: begin
                if (!lastX) begin
                    stp = 1'b1;
                end else if (tall) begin
                    ld     = 1'b1;
                    ldBase = rowNext;
                    ldX    = xMinR;
                end
            end
            LEFT: begin
                if (!lastY) begin
                    stp    = 1'b1;
                    rowStp = 1'b1;
                end else if (xMinR != xMaxR) begin
                    ld     = 1'b1;
                    ldBase = rowNext;
                    ldX    = xMaxR;
                end
            end
            RIGHT: begin
                stp    = !lastY;
                rowStp = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdyR    <= 1'b1;
            wrenR   <= 1'b0;
            errR    <= 1'b0;
            wrdataR <= '0;
            xMinR   <= '0;
            xMaxR   <= '0;
            yMinR   <= '0;
            yMaxR   <= '0;
            xCur    <= '0;
            yCur    <= '0;
            rowTopR <= '0;
            rowBotR <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        xMinR   <= bus.xMin;
                        xMaxR   <= bus.xMax;
                        yMinR   <= bus.yMin;
                        yMaxR   <= bus.yMax;
                        xCur    <= bus.xMin;
                        rowTopR <= rowIn;
                        rowBotR <= rowInBot;
                        wrdataR <= bus.colour;
                        rdyR    <= 1'b0;
                        if (badBox) begin
                            state <= REJECT;
                            errR  <= 1'b1;
                        end else begin
                            state <= TOP;
                            wrenR <= 1'b1;
                        end
                    end
                end
                TOP: begin
                    if (!lastX) begin
                        xCur <= xCur + COORD_W'(1);
                    end else if (yMinR != yMaxR) begin
                        xCur  <= xMinR;
                        state <= BOTTOM;
                    end else begin
                        state <= IDLE;
                        wrenR <= 1'b0;
                        rdyR  <= 1'b1;
                    end
                end
                BOTTOM: begin
                    if (!lastX) begin
                        xCur <= xCur + COORD_W'(1);
                    end else if (tall) begin
                        yCur  <= yMinR + COORD_W'(1);
                        state <= LEFT;
                    end else begin
                        state <= IDLE;
                        wrenR <= 1'b0;
                        rdyR  <= 1'b1;
                    end
                end
                LEFT: begin
                    if (!lastY) begin
                        yCur <= yCur + COORD_W'(1);
                    end else if (xMinR != xMaxR) begin
                        yCur  <= yMinR + COORD_W'(1);
                        state <= RIGHT;
                    end else begin
                        state <= IDLE;
                        wrenR <= 1'b0;
                        rdyR  <= 1'b1;
                    end
                end
                RIGHT: begin
                    if (!lastY) begin
                        yCur <= yCur + COORD_W'(1);
                    end else begin
                        state <= IDLE;
                        wrenR <= 1'b0;
                        rdyR  <= 1'b1;
                    end
                end
                REJECT: begin
                    errR  <= 1'b0;
                    rdyR  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    bbox_addr_gen #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ld),
        .step    (stp),
        .rowStep (rowStp),
        .base    (ldBase),
        .x       (ldX),
        .addr    (addrW)
    );

    assign bus.rdy    = rdyR;
    assign bus.wren   = wrenR;
    assign bus.err    = errR;
    assign bus.wrdata = wrdataR;
    assign bus.addr   = addrW;

endmodule

// File: tb/tb_bbox_draw.sv
// Random and directed boxes checked against a pixel-list model
// of the outline built straight from the box geometry.
module tb_bbox_draw;

    localparam int W  = 100;
    localparam int H  = 100;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nErrors = 0;
    int   expQ[$];
    bit   expBad;

    bbox_draw_if #(.ADDR_W(AW)) bus ();

    bbox_draw #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outline as an ordered pixel list, each pixel once
    task automatic buildExp(input int x0, input int x1,
                            input int y0, input int y1);
        expQ.delete();
        expBad = (x0 > x1) || (y0 > y1) || (x1 >= W) || (y1 >= H);
        if (expBad) return;
        for (int x = x0; x <= x1; x++) expQ.push_back(y0 * W + x);
        if (y1 != y0)
            for (int x = x0; x <= x1; x++) expQ.push_back(y1 * W + x);
        for (int y = y0 + 1; y < y1; y++) expQ.push_back(y * W + x0);
        if (x1 != x0)
            for (int y = y0 + 1; y < y1; y++) expQ.push_back(y * W + x1);
    endtask

    task automatic scramble();
        bus.xMin   = 11'($urandom_range(0, 120));
        bus.xMax   = 11'($urandom_range(0, 120));
        bus.yMin   = 11'($urandom_range(0, 120));
        bus.yMax   = 11'($urandom_range(0, 120));
        bus.colour = 8'($urandom_range(0, 255));
    endtask

    // Caller is at a negedge; hold keeps en high with junk inputs
    task automatic doBox(input int x0, input int x1, input int y0,
                         input int y1, input int col, input bit hold);
        int t;
        t = 0;
        while (!bus.rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rdy) begin
            chk("rdyWait", 0, 1);
            return;
        end
        buildExp(x0, x1, y0, y1);
        bus.xMin   = 11'(x0);
        bus.xMax   = 11'(x1);
        bus.yMin   = 11'(y0);
        bus.yMax   = 11'(y1);
        bus.colour = 8'(col);
        bus.en     = 1'b1;
        @(posedge clk);
        #1;
        if (hold) scramble();
        else bus.en = 1'b0;
        if (expBad) begin
            @(negedge clk);
            chk("rejErr", int'(bus.err), 1);
            chk("rejWren", int'(bus.wren), 0);
            chk("rejRdy", int'(bus.rdy), 0);
            @(negedge clk);
            chk("rejErrEnd", int'(bus.err), 0);
            chk("rejWrenEnd", int'(bus.wren), 0);
            chk("rejRdyEnd", int'(bus.rdy), 1);
        end else begin
            foreach (expQ[k]) begin
                @(negedge clk);
                chk("wren", int'(bus.wren), 1);
                chk("addr", int'(bus.addr), expQ[k]);
                chk("wrdata", int'(bus.wrdata), col);
                chk("busyRdy", int'(bus.rdy), 0);
                chk("busyErr", int'(bus.err), 0);
                if (hold) scramble();
            end
            @(negedge clk);
            chk("doneWren", int'(bus.wren), 0);
            chk("doneRdy", int'(bus.rdy), 1);
            chk("doneErr", int'(bus.err), 0);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        int x0, x1, y0, y1, writes;
        bus.en = 1'b0;
        scramble();

        repeat (3) @(negedge clk);
        chk("rstRdy", int'(bus.rdy), 1);
        chk("rstWren", int'(bus.wren), 0);
        chk("rstErr", int'(bus.err), 0);
        chk("rstAddr", int'(bus.addr), 0);
        chk("rstWrdata", int'(bus.wrdata), 0);
        rst_n = 1'b1;
        @(negedge clk);

        doBox(2, 5, 3, 6, 8'hAA, 1'b0);
        doBox(7, 7, 7, 7, 8'h11, 1'b0);
        doBox(99, 0, 99, 0, 8'h22, 1'b0);
        doBox(0, 100, 0, 5, 8'h33, 1'b0);
        doBox(0, 1, 0, 1, 8'h44, 1'b1);
        doBox(0, 99, 0, 99, 8'h55, 1'b0);
        doBox(99, 99, 0, 99, 8'h66, 1'b0);
        doBox(0, 99, 99, 99, 8'h77, 1'b0);
        doBox(4, 9, 20, 21, 8'h88, 1'b0);

        // Reset during a draw after the third write
        doBox(0, 0, 0, 0, 8'h01, 1'b0);
        bus.xMin = 11'd10;
        bus.xMax = 11'd20;
        bus.yMin = 11'd10;
        bus.yMax = 11'd20;
        bus.colour = 8'h99;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        writes = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.wren) writes++;
            chk("rstDrawAddr", int'(bus.addr), 1010 + k);
        end
        rst_n = 1'b0;
        #1;
        chk("abortWren", int'(bus.wren), 0);
        chk("abortRdy", int'(bus.rdy), 1);
        chk("abortAddr", int'(bus.addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.wren) writes++;
        end
        chk("abortWrites", writes, 3);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) != 0) begin
                x0 = $urandom_range(0, 99);
                x1 = $urandom_range(x0, (x0 + 12 > 99) ? 99 : x0 + 12);
                y0 = $urandom_range(0, 99);
                y1 = $urandom_range(y0, (y0 + 12 > 99) ? 99 : y0 + 12);
            end else begin
                x0 = $urandom_range(0, 120);
                x1 = $urandom_range(0, 120);
                y0 = $urandom_range(0, 120);
                y1 = $urandom_range(0, 120);
            end
            doBox(x0, x1, y0, y1, $urandom_range(0, 255),
                  1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end

endmodule
